// File: rtl/stoch_mult_sched_if.sv
// Bundle of signals between the multiplier scheduler, its requesters, the
// shared stochastic multiplier and the result consumer.
// master: the environment (requesters, multiplier, result sink).
// slave : the scheduler itself.
interface stoch_mult_sched_if #(
  parameter int N_REQ      = 4,
  parameter int STREAM_LEN = 256,
  parameter int ID_W       = $clog2(N_REQ),
  parameter int ACC_W      = $clog2(STREAM_LEN) + 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        a_p;
  logic [N_REQ-1:0]        a_m;
  logic [N_REQ-1:0]        b_p;
  logic [N_REQ-1:0]        b_m;
  logic                    mult_a_p;
  logic                    mult_a_m;
  logic                    mult_b_p;
  logic                    mult_b_m;
  logic                    mult_nrst;
  logic                    mult_y_p;
  logic                    mult_y_m;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic signed [ACC_W-1:0] res_value;

  modport master (
    output req_valid, a_p, a_m, b_p, b_m,
    input  req_ready,
    input  mult_a_p, mult_a_m, mult_b_p, mult_b_m, mult_nrst,
    output mult_y_p, mult_y_m,
    input  res_valid, res_id, res_value,
    output res_ready
  );

  modport slave (
    input  req_valid, a_p, a_m, b_p, b_m,
    output req_ready,
    output mult_a_p, mult_a_m, mult_b_p, mult_b_m, mult_nrst,
    input  mult_y_p, mult_y_m,
    output res_valid, res_id, res_value,
    input  res_ready
  );
endinterface

// File: rtl/stoch_mult_sched.sv
// stoch_mult_sched: time-shares one stochastic bipolar multiplier among
// N_REQ requesters. A granted requester streams STREAM_LEN valid bit pairs
// through the multiplier; the (y_p - y_m) output is integrated into a signed
// count returned on a valid/ready result port. The multiplier is flushed via
// mult_nrst before every job.
// Build option: define STOCH_MULT_SCHED_FIXED_PRI_EN for lowest-index-first
// arbitration (no round-robin pointer); default is round-robin.
module stoch_mult_sched #(
  parameter int N_REQ      = 4,
  parameter int STREAM_LEN = 256,
  parameter int MULT_LAT   = 2,
  parameter int FLUSH_CYC  = 2,
  parameter int ID_W       = $clog2(N_REQ),
  parameter int ACC_W      = $clog2(STREAM_LEN) + 2
) (
  input logic               clk,
  input logic               rst,
  stoch_mult_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W = $clog2(STREAM_LEN + 1);
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);

  logic [2:0]              state_q;
  logic [2:0]              state_d;
  logic [ID_W-1:0]         grant_q;
  logic [ID_W-1:0]         pick;
  logic                    pick_found;
  logic [FL_W-1:0]         flush_cnt_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    consume;
  logic [MULT_LAT-1:0]     tag_vld_p;
  logic [MULT_LAT-1:0]     tag_next;
  logic signed [ACC_W-1:0] acc_q;
  logic                    res_valid_q;
  logic                    mult_nrst_q;

  // One integration step: +1, -1 or unchanged depending on the output pair.
  function automatic logic signed [ACC_W-1:0] acc_step(
    input logic signed [ACC_W-1:0] acc,
    input logic                    yp,
    input logic                    ym
  );
    logic signed [ACC_W-1:0] delta;
    delta = '0;
    if (yp && !ym) delta = {{(ACC_W-1){1'b0}}, 1'b1};
    else if (!yp && ym) delta = '1;
    return acc + delta;
  endfunction

  assign consume = (state_q == S_RUN) && bus.req_valid[grant_q];

`ifdef STOCH_MULT_SCHED_FIXED_PRI_EN
  // Grant selection: lowest-index valid requester wins.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[ID_W'(k)]) begin
        pick       = ID_W'(k);
        pick_found = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q;
  int              rr_idx;

  // Grant selection: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    rr_idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!pick_found && bus.req_valid[ID_W'(rr_idx)]) begin
        pick       = ID_W'(rr_idx);
        pick_found = 1'b1;
      end
    end
  end

  // Round-robin pointer advances past the served requester on result accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (state_q == S_DONE && bus.res_ready) begin
      rr_ptr_q <= (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
    end
  end
`endif

  // Tag pipeline input side: consumed flag enters, everything shifts by one.
  always_comb begin
    tag_next[0] = consume;
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_next[i] = tag_vld_p[i-1];
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found) state_d = S_FLUSH;
      S_FLUSH: if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) state_d = S_RUN;
      S_RUN:   if (consume && bit_cnt_q == CNT_W'(STREAM_LEN - 1)) state_d = S_DRAIN;
      S_DRAIN: if (tag_next == '0) state_d = S_DONE;
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, latched grant and registered handshake/flush outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      res_valid_q <= 1'b0;
      mult_nrst_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      res_valid_q <= (state_d == S_DONE);
      mult_nrst_q <= (state_d != S_FLUSH);
      if (state_q == S_IDLE && pick_found) grant_q <= pick;
    end
  end

  // Flush-length and consumed-bit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
      bit_cnt_q   <= '0;
    end else begin
      flush_cnt_q <= (state_q == S_FLUSH) ? flush_cnt_q + FL_W'(1) : '0;
      if (state_q == S_FLUSH) bit_cnt_q <= '0;
      else if (consume)       bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // Stage p0..pN: consumed-bit tags travel alongside the multiplier latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_p <= '0;
    end else if (state_q == S_FLUSH) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p <= tag_next;
    end
  end

  // Output stage: integrate multiplier output whenever its tag is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (state_q == S_FLUSH) begin
      acc_q <= '0;
    end else if (tag_vld_p[MULT_LAT-1]) begin
      acc_q <= acc_step(acc_q, bus.mult_y_p, bus.mult_y_m);
    end
  end

  // Combinational routing of the granted requester into the multiplier.
  always_comb begin
    bus.req_ready = '0;
    bus.mult_a_p  = 1'b0;
    bus.mult_a_m  = 1'b0;
    bus.mult_b_p  = 1'b0;
    bus.mult_b_m  = 1'b0;
    if (consume) begin
      bus.req_ready[grant_q] = 1'b1;
      bus.mult_a_p           = bus.a_p[grant_q];
      bus.mult_a_m           = bus.a_m[grant_q];
      bus.mult_b_p           = bus.b_p[grant_q];
      bus.mult_b_m           = bus.b_m[grant_q];
    end
  end

  assign bus.mult_nrst = mult_nrst_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = grant_q;
  assign bus.res_value = acc_q;

endmodule

// File: doc/stoch_mult_sched.md
# stoch_mult_sched

Time-shares one `stoch_signed_mult` instance among N_REQ requesters.
- Round-robin grant to one requester; its bipolar bitstream pair is routed into the multiplier for STREAM_LEN valid cycles.
- The multiplier's (y_p − y_m) output is integrated into a signed count and returned on a valid/ready result port.
- Between jobs the multiplier is flushed through its `nRST` so state never leaks across requesters.

## Interface
- N_REQ, 4, number of requesters (≥2)
- STREAM_LEN, 256, valid bit-cycles per job (≥2)
- MULT_LAT, 2, cycles from multiplier input to matching output
- FLUSH_CYC, 2, cycles `mult_nrst` is held low before each job
- ID_W, $clog2(N_REQ), requester index width
- ACC_W, $clog2(STREAM_LEN)+2, signed result width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i has a job / current bit valid
- req_ready  out  N_REQ  one-hot; bit i consumed this cycle
- a_p, a_m, b_p, b_m  in  N_REQ each  per-requester operand bitstreams
- mult_a_p, mult_a_m, mult_b_p, mult_b_m  out  1  to shared multiplier
- mult_nrst  out  1  active-low flush to shared multiplier
- mult_y_p, mult_y_m  in  1  multiplier outputs
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_id  out  ID_W  requester that produced the result
- res_value  out  ACC_W  signed two's-complement Σ(y_p − y_m)

## Operation
- FSM states: IDLE, FLUSH, RUN, DRAIN, DONE.
- IDLE: if any req_valid, grant = first set bit at or after rr_ptr (wrapping). Latch the grant, go to FLUSH. Otherwise stay.
- FLUSH: mult_nrst=0 for FLUSH_CYC cycles; clear accumulator and bit counter; go to RUN.
- RUN:
  - req_ready[grant] = req_valid[grant]. Mult inputs = granted operands when req_valid[grant], else all 0 (stall bubble).
  - bit_cnt increments on each consumed bit. After the STREAM_LEN-th consumed bit, go to DRAIN.
- Tag pipeline: MULT_LAT-deep shift register of the consumed flag. When the tag at the output end is set, accumulator += (mult_y_p − mult_y_m), i.e. +1, −1 or 0. Untagged outputs are ignored.
- DRAIN: mult inputs 0, req_ready 0. Go to DONE once the tag pipeline is empty.
- DONE: res_valid=1; res_id and res_value stable. On res_ready: rr_ptr = grant+1 mod N_REQ, go to IDLE.
- Outside RUN, all req_ready bits are 0. Non-granted requesters are never ready.
- Accumulator range −STREAM_LEN..+STREAM_LEN; ACC_W guarantees no overflow.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0
  - req_ready 0, mult_* data 0, mult_nrst 1
  - res_valid 0, res_id 0, res_value 0
- All outputs are registered except req_ready and mult data, which are combinational from state and req_valid.
- Latency with no stalls, first req_valid to res_valid: 1 (IDLE) + FLUSH_CYC + STREAM_LEN + MULT_LAT cycles. Each stall cycle adds 1.
- A requester dropping req_valid mid-RUN stalls the job. The job is never aborted, and the grant is held indefinitely.
- res_ready asserted while res_valid=0 is ignored. New req_valid during DONE waits until IDLE.
- Simultaneous res_ready and pending requests: next grant is decided in the IDLE cycle after DONE. There is no back-to-back skip of IDLE.
- RST mid-job: immediate return to reset values and the job is discarded. Requesters must re-present.
- rr_ptr wraps N_REQ−1 → 0.

## Configuration
- STOCH_MULT_SCHED_FIXED_PRI_EN defined: the grant always goes to the lowest-index valid requester, and rr_ptr is not implemented.
- Undefined (default): round-robin as above.

## Test plan
Bench drives a stub multiplier with latency MULT_LAT: y_p = (a_p&b_p)|(a_m&b_m), y_m = (a_p&b_m)|(a_m&b_p). Use STREAM_LEN=16.
- Req 0 only, a_p=b_p=1 constant → res_id=0, res_value=+16, res_valid at cycle 1+2+16+2=21.
- Req 2 only, a_p=1, b_m=1 → res_value=−16. Alternating a_p/a_m with b_p=1 → res_value=0.
- Req 0 and 3 both held valid, then repeated → grant order 0,3,0,3. With FIXED_PRI_EN the order is 0,0,0.
- Req 1 deasserts valid for 5 cycles mid-RUN → req_ready follows valid, stub inputs 0 during the gap, res_value still +16, latency +5.
- res_ready held low for 10 cycles in DONE → res_valid/res_id/res_value stable, no new grant. Then res_ready=1 → IDLE next cycle.
- RST pulse during RUN → all outputs at reset values immediately. Re-request → full-length job, correct value.
